// File: rtl/key_hex_counter.sv
// ---------------------------------------------------------------------------
// key_hex_counter
//
// Debounces one raw, active-low push button and counts the accepted presses
// in a 4-bit wrapping hex register. The register feeds a single-digit
// seven-segment encoder. The block also exports a one-cycle press strobe and
// the debounced key level to other logic.
//
// Ports:
//   clk        system clock, all state changes on its rising edge
//   rst        asynchronous, active-high reset
//   key_in     raw button level, asynchronous to clk, 0 = pressed
//   clr        synchronous, level-sensitive clear of the press count
//   value      press count 0x0..0xF (seven-segment encoder input)
//   key_flag   one-cycle pulse on each accepted press
//   key_state  debounced level, 1 = pressed
//
// Parameters:
//   CNT_MAX    consecutive stable samples required to accept a key edge (>= 2)
// ---------------------------------------------------------------------------
module key_hex_counter #(
    parameter int CNT_MAX = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    input  logic       clr,
    output logic [3:0] value,
    output logic       key_flag,
    output logic       key_state
);

    localparam int CNT_W = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Debounce FSM encoding
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FILT_DN = 2'd1;
    localparam logic [1:0] DOWN    = 2'd2;
    localparam logic [1:0] FILT_UP = 2'd3;

    logic             sync1_q;
    logic             sync2_q;
    logic             key_s;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;

    logic [3:0]       value_q;
    logic [3:0]       value_d;
    logic             flag_q;
    logic             flag_d;
    logic             keystate_q;
    logic             keystate_d;

    // Two-flop synchronizer; resets to the released level so a reset never
    // looks like the start of a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    assign key_s = sync2_q;

    // Debounce FSM. Each filter state counts consecutive samples at the new
    // level; any sample back at the old level abandons the filter. A press is
    // accepted on the CNT_MAX-th consecutive low sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!key_s) begin
                    state_d = FILT_DN;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            FILT_DN: begin
                if (key_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            DOWN: begin
                if (key_s) begin
                    state_d = FILT_UP;
                    cnt_d   = CNT_ONE;
                end
            end
            FILT_UP: begin
                if (!key_s) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next-state: clear dominates an acceptance on the same edge, but
    // the strobe and the debounced level are unaffected by clear.
    always_comb begin
        value_d    = value_q;
        if (clr) begin
            value_d = 4'h0;
        end else if (accept) begin
            value_d = value_q + 4'h1;
        end
        flag_d     = accept;
        keystate_d = (state_d == DOWN) || (state_d == FILT_UP);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            value_q    <= 4'h0;
            flag_q     <= 1'b0;
            keystate_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            value_q    <= value_d;
            flag_q     <= flag_d;
            keystate_q <= keystate_d;
        end
    end

    assign value     = value_q;
    assign key_flag  = flag_q;
    assign key_state = keystate_q;

endmodule

// File: tb/tb_key_hex_counter.sv
// ---------------------------------------------------------------------------
// tb_key_hex_counter
//
// Self-checking bench for key_hex_counter with CNT_MAX = 8. A run-length
// reference model tracks the debounced level, press strobe and press count;
// a per-cycle compare process checks the DUT against it, and directed
// scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_key_hex_counter;

    localparam int CNT_MAX = 8;

    logic       clk;
    logic       rst;
    logic       key_in;
    logic       clr;
    logic [3:0] value;
    logic       key_flag;
    logic       key_state;

    int total     = 0;
    int bad       = 0;
    int flagCount = 0;
    int base      = 0;
    int lowSeen   = 0;

    // Reference model: two-sample delay line, debounced level, and the number
    // of consecutive samples that disagree with that level.
    logic       s1M    = 1'b1;
    logic       s2M    = 1'b1;
    logic       lvlM   = 1'b0;
    int         runM   = 0;
    logic [3:0] valM   = 4'h0;
    logic       flagM  = 1'b0;

    key_hex_counter #(
        .CNT_MAX(CNT_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .clr      (clr),
        .value    (value),
        .key_flag (key_flag),
        .key_state(key_state)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge (or hold it in reset)
    task automatic modelStep();
        logic pressedNow;
        if (rst) begin
            s1M   = 1'b1;
            s2M   = 1'b1;
            lvlM  = 1'b0;
            runM  = 0;
            valM  = 4'h0;
            flagM = 1'b0;
        end else begin
            pressedNow = !s2M;
            s2M   = s1M;
            s1M   = key_in;
            flagM = 1'b0;
            if (pressedNow != lvlM) begin
                runM++;
                if (runM == CNT_MAX) begin
                    lvlM = pressedNow;
                    runM = 0;
                    if (pressedNow) begin
                        flagM = 1'b1;
                        valM  = valM + 4'h1;
                    end
                end
            end else begin
                runM = 0;
            end
            if (clr) valM = 4'h0;
        end
    endtask

    task automatic modelLoop();
        forever begin
            @(posedge clk or posedge rst);
            modelStep();
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    task automatic compareLoop();
        forever begin
            @(negedge clk);
            checkOutput("model_value", {28'd0, value}, {28'd0, valM});
            checkOutput("model_flag", {31'd0, key_flag}, {31'd0, flagM});
            checkOutput("model_state", {31'd0, key_state}, {31'd0, lvlM});
            if (key_flag) flagCount++;
        end
    endtask

    // Hold key_in at lvl for n clock edges, starting just after a negedge
    task automatic applyStimulus(input logic lvl, input int n);
        key_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst    = 1'b1;
        key_in = 1'b1;
        clr    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // One clean press, optionally with clr high on the acceptance edge
    task automatic pressOnce(input logic doClr);
        key_in = 1'b0;
        repeat (9) @(negedge clk);
        clr = doClr;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("accept_flag", {31'd0, key_flag}, 32'd1);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 14);
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        key_in = 1'b1;
        clr    = 1'b0;
        fork
            modelLoop();
            compareLoop();
        join_none

        // Reset state before any clock edge
        #2;
        checkOutput("reset_value", {28'd0, value}, 32'd0);
        checkOutput("reset_flag", {31'd0, key_flag}, 32'd0);
        checkOutput("reset_state", {31'd0, key_state}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Clean press: flag only after edge 9
        base   = flagCount;
        key_in = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checkOutput("press_flag_e8", {31'd0, key_flag}, 32'd0);
        checkOutput("press_state_e8", {31'd0, key_state}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("press_flag_e9", {31'd0, key_flag}, 32'd1);
        checkOutput("press_value_e9", {28'd0, value}, 32'd1);
        checkOutput("press_state_e9", {31'd0, key_state}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("press_flag_oneshot", {31'd0, key_flag}, 32'd0);
        @(negedge clk);
        repeat (19) @(negedge clk);
        key_in = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        checkOutput("release_state_e8", {31'd0, key_state}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("release_state_e9", {31'd0, key_state}, 32'd0);
        checkOutput("release_no_flag", {31'd0, key_flag}, 32'd0);
        @(negedge clk);
        repeat (4) @(negedge clk);
        checkOutput("press_flag_count", flagCount - base, 32'd1);
        checkOutput("press_value_final", {28'd0, value}, 32'd1);

        // Asynchronous reset while the key is held down
        applyStimulus(1'b0, 12);
        checkOutput("held_value", {28'd0, value}, 32'd2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_value", {28'd0, value}, 32'd0);
        checkOutput("async_rst_state", {31'd0, key_state}, 32'd0);
        checkOutput("async_rst_flag", {31'd0, key_flag}, 32'd0);
        key_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Press bounce: low 5, high 1, then low; flag 9 edges after last fall
        applyReset();
        base = flagCount;
        applyStimulus(1'b0, 5);
        applyStimulus(1'b1, 1);
        key_in = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checkOutput("bounce_flag_e8", {31'd0, key_flag}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("bounce_flag_e9", {31'd0, key_flag}, 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 10);
        checkOutput("bounce_flag_count", flagCount - base, 32'd1);
        checkOutput("bounce_value", {28'd0, value}, 32'd1);

        // Release bounce while DOWN: 4 high samples then low again
        lowSeen = 0;
        key_in  = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 4) key_in = 1'b0;
            @(negedge clk);
            if (!key_state) lowSeen++;
        end
        checkOutput("relbounce_state_low_cycles", lowSeen, 32'd0);
        checkOutput("relbounce_flag_count", flagCount - base, 32'd1);
        checkOutput("relbounce_value", {28'd0, value}, 32'd1);
        applyStimulus(1'b1, 14);
        checkOutput("relbounce_released", {31'd0, key_state}, 32'd0);

        // A standalone clr pulse
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("clr_pulse_value", {28'd0, value}, 32'd0);

        // Wrap and clear
        applyReset();
        base = flagCount;
        for (int p = 0; p < 16; p++) pressOnce(1'b0);
        checkOutput("wrap_value", {28'd0, value}, 32'd0);
        checkOutput("wrap_flag_count", flagCount - base, 32'd16);
        pressOnce(1'b1);
        checkOutput("clr_accept_value", {28'd0, value}, 32'd0);
        checkOutput("clr_accept_flag_count", flagCount - base, 32'd17);
        pressOnce(1'b0);
        checkOutput("after_clr_value", {28'd0, value}, 32'd1);

        // Reset mid-filter with key held low throughout
        applyReset();
        key_in = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst  = 1'b1;
        base = flagCount;
        @(negedge clk);
        checkOutput("midrst_flag_a", {31'd0, key_flag}, 32'd0);
        @(negedge clk);
        checkOutput("midrst_flag_b", {31'd0, key_flag}, 32'd0);
        rst = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checkOutput("midrst_flag_e9", {31'd0, key_flag}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("midrst_flag_e10", {31'd0, key_flag}, 32'd1);
        checkOutput("midrst_value", {28'd0, value}, 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 14);
        checkOutput("midrst_flag_count", flagCount - base, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_hex_counter.md
Name: key_hex_counter

Overview:
- Debounces one raw, active-low mechanical push button.
- Counts confirmed presses in a 4-bit hex register that wraps around.
- Sits directly upstream of the single-digit seven-segment encoder, whose 4-bit input takes `value`.
- Also gives a one-cycle press strobe and the debounced key level to other logic.

Parameters:
- CNT_MAX, 1_000_000, number of consecutive stable samples needed to accept a key edge. This is 20 ms at 50 MHz. Legal range is ≥2. Benches use 8.
- CNT_W, $clog2(CNT_MAX), width of the debounce counter. Derived; do not override.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- key_in  input  1  raw button, asynchronous to clk. 0 = pressed.
- clr  input  1  synchronous clear of `value`, active-high, level-sensitive.
- value  output  4  press count, 0x0–0xF. Drives the seven-segment encoder input.
- key_flag  output  1  one-cycle pulse on each accepted press.
- key_state  output  1  debounced level. 1 = pressed.

Behaviour:
- Reset (rst=1, takes effect immediately, asynchronous):
  - both synchronizer flops = 1 (released);
  - FSM = IDLE, debounce counter = 0;
  - value = 4'h0, key_flag = 0, key_state = 0.
- Synchronizer: two flops in series; key_s is the second flop. key_s lags key_in by 2 edges. Only key_s feeds the FSM.
- FSM states and transitions, evaluated every edge:
  - IDLE: if key_s = 0, go to FILT_DN with counter = 1. Otherwise stay, with counter = 0.
  - FILT_DN:
    - if key_s = 1 (bounce), go to IDLE with counter = 0;
    - else if counter = CNT_MAX-1, go to DOWN with counter = 0, and on the same edge set key_flag = 1 and increment value;
    - else increment the counter.
  - DOWN: if key_s = 1, go to FILT_UP with counter = 1. Otherwise stay.
  - FILT_UP:
    - if key_s = 0 (bounce), return to DOWN with counter = 0 and no flag;
    - else if counter = CNT_MAX-1, go to IDLE with counter = 0;
    - else increment the counter.
- Press acceptance: a press is accepted on the CNT_MAX-th consecutive low sample of key_s. Latency from key_in falling before edge 0 to key_flag = 1 is after edge CNT_MAX+1.
- Release: release is also debounced. It produces no strobe.
- key_flag: registered. High for exactly one cycle per accepted press. Never asserted on release.
- key_state: registered. 1 while the FSM is in DOWN or FILT_UP, 0 in IDLE or FILT_DN. It goes to 1 on the same edge as key_flag.
- value arithmetic: modulo 16, so 4'hF + 1 = 4'h0 with no carry out.
- clr:
  - clr = 1 forces value to 0 on the next edge;
  - if clr and an acceptance occur on the same edge, clr wins: value = 0, but key_flag still pulses;
  - clr does not affect the FSM, the counter, key_flag or key_state.
- Holding the button: a held button produces exactly one increment. There is no auto-repeat.
- Reset mid-operation: rst asserted in any state (including mid-filter) returns everything to its reset values. No flag is emitted on the way out.
  - After rst is released with key_in already low, a fresh full debounce is required. That yields one press, with flag latency CNT_MAX+2 edges counted from rst deassertion.
- Counter saturation: the counter never exceeds CNT_MAX-1, and no out-of-range state is reachable. The default branch goes to IDLE with counter = 0.

Test Plan (CNT_MAX=8):
- Reset check: assert rst asynchronously mid-cycle. Required: value = 0, key_flag = 0, key_state = 0 immediately, without waiting for a clock edge.
- Clean press: key_in low before edge 0, held 30 cycles, then high. Required:
  - key_flag = 1 only after edge 9;
  - value 0→1 on that edge;
  - key_state = 1 from edge 9 until 10 edges after release (2 sync + 8 filter).
- Press bounce: key_in low for 5 cycles, high 1 cycle, low 20 cycles. Required: exactly one flag, issued 9 edges after the final falling edge; value = 1.
- Release bounce: while DOWN, key_in high for 4 cycles then low again. Required: key_state stays 1, no flag, value unchanged.
- Wrap and clear:
  - 16 clean presses from 0 give value = 0x0;
  - a 17th press with clr = 1 on the acceptance edge gives key_flag = 1 and value = 0x0;
  - an 18th press with clr = 0 gives value = 0x1.
- Reset mid-filter: rst pulsed while in FILT_DN (counter = 5), key_in held low throughout. Required: no flag during the reset pulse; one flag after rst release following the full filter; value = 1.
